// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: 32 shift-add or restoring-divide steps
// bracketed by an operand-capture cycle and a sign-fix cycle (33 cycles accept-to-done).
module muldiv_unit #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] rs1,
  input  logic [XLEN-1:0] rs2,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);

  typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

  localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

  state_t          state;
  logic [5:0]      cnt;
  logic [2:0]      op;
  logic            s1, s2;
  logic [XLEN-1:0] op_a, op_b;
  logic [XLEN-1:0] operand;
  logic [XLEN-1:0] acc_hi, acc_lo;

  logic            sgn1_in, sgn2_in, neg1_in, neg2_in;
  logic [XLEN-1:0] mag1_in, mag2_in;
  logic [XLEN:0]   mul_sum, div_shift, div_trial;
  logic [2*XLEN-1:0] product, product_fix;
  logic            prod_neg, div_zero, div_ovf;
  logic [XLEN-1:0] quotient, remainder, fix_result;

  // Operand signedness is decided from funct3 at accept; magnitudes feed an unsigned datapath.
  always_comb begin
    sgn1_in = funct3 inside {3'b001, 3'b010, 3'b100, 3'b110};
    sgn2_in = funct3 inside {3'b001, 3'b100, 3'b110};
    neg1_in = sgn1_in & rs1[XLEN-1];
    neg2_in = sgn2_in & rs2[XLEN-1];
    mag1_in = neg1_in ? -rs1 : rs1;
    mag2_in = neg2_in ? -rs2 : rs2;
  end

  // acc_lo holds the multiplier (multiply) or the dividend shifting into the quotient (divide).
  always_comb begin
    mul_sum   = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, operand} : '0);
    div_shift = {acc_hi, acc_lo[XLEN-1]};
    div_trial = div_shift - {1'b0, operand};
  end

  always_comb begin
    product     = {acc_hi, acc_lo};
    prod_neg    = (op == 3'b001) ? (s1 ^ s2) : (op == 3'b010) ? s1 : 1'b0;
    product_fix = prod_neg ? -product : product;
    div_zero    = (op_b == '0);
    div_ovf     = !op[0] && (op_a == MIN_NEG) && (op_b == '1);
    quotient    = (s1 ^ s2) ? -acc_lo : acc_lo;
    remainder   = s1 ? -acc_hi : acc_hi;
    if (div_zero) begin
      quotient  = '1;
      remainder = op_a;
    end else if (div_ovf) begin
      quotient  = MIN_NEG;
      remainder = '0;
    end
    if (op[2])
      fix_result = op[1] ? remainder : quotient;
    else
      fix_result = (op[1:0] == 2'b00) ? product_fix[XLEN-1:0] : product_fix[2*XLEN-1:XLEN];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= '0;
      op      <= '0;
      s1      <= 1'b0;
      s2      <= 1'b0;
      op_a    <= '0;
      op_b    <= '0;
      operand <= '0;
      acc_hi  <= '0;
      acc_lo  <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      result  <= '0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            op      <= funct3;
            s1      <= neg1_in;
            s2      <= neg2_in;
            op_a    <= rs1;
            op_b    <= rs2;
            operand <= funct3[2] ? mag2_in : mag1_in;
            acc_hi  <= '0;
            acc_lo  <= funct3[2] ? mag1_in : mag2_in;
            cnt     <= '0;
            busy    <= 1'b1;
            state   <= CALC;
          end
        end
        CALC: begin
          if (op[2]) begin
            if (!div_trial[XLEN]) begin
              acc_hi <= div_trial[XLEN-1:0];
              acc_lo <= {acc_lo[XLEN-2:0], 1'b1};
            end else begin
              acc_hi <= div_shift[XLEN-1:0];
              acc_lo <= {acc_lo[XLEN-2:0], 1'b0};
            end
          end else begin
            {acc_hi, acc_lo} <= {mul_sum, acc_lo[XLEN-1:1]};
          end
          cnt <= cnt + 6'd1;
          if (cnt == 6'd31)
            state <= FIX;
        end
        FIX: begin
          result <= fix_result;
          done   <= 1'b1;
          busy   <= 1'b0;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit: expected results queued at accept, checked
// (value and 33-cycle latency) whenever done pulses.
module tb_muldiv_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [2:0]  funct3;
  logic [31:0] rs1, rs2;
  logic        busy, done;
  logic [31:0] result;

  typedef struct {
    string       tag;
    logic [31:0] value;
    int          acc;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  int   done_cnt = 0;

  muldiv_unit #(.XLEN(32)) dut (
    .clk(clk), .rst(rst), .start(start), .funct3(funct3),
    .rs1(rs1), .rs2(rs2), .busy(busy), .done(done), .result(result)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Independent reference built on the simulator's own arithmetic operators.
  function automatic logic [31:0] refModel(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] p;
    logic signed [31:0] sa, sbv;
    sa = a;
    sbv = b;
    case (f)
      3'd0: begin p = {32'b0, a} * {32'b0, b}; return p[31:0]; end
      3'd1: begin p = {{32{a[31]}}, a} * {{32{b[31]}}, b}; return p[63:32]; end
      3'd2: begin p = {{32{a[31]}}, a} * {32'b0, b}; return p[63:32]; end
      3'd3: begin p = {32'b0, a} * {32'b0, b}; return p[63:32]; end
      3'd4: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
        return sa / sbv;
      end
      3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'd6: begin
        if (b == 0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h0;
        return sa % sbv;
      end
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  always @(negedge clk) begin
    if (!rst && done) begin
      done_cnt++;
      if (sb.size() == 0) begin
        checkOutput("unexpected_done", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        checkOutput(e.tag, result, e.value);
        checkOutput({e.tag, "_latency"}, cyc - e.acc, 32'd33);
      end
    end
  end

  task automatic pushExpect(input string tag, input logic [31:0] value, input int acc);
    exp_t e;
    e.tag = tag;
    e.value = value;
    e.acc = acc;
    sb.push_back(e);
  endtask

  task automatic applyStimulus(input string tag, input logic [2:0] f, input logic [31:0] a,
                               input logic [31:0] b, input logic [31:0] exp);
    int guard = 0;
    @(negedge clk);
    while (busy && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    checkOutput({tag, "_idle"}, {31'b0, busy}, 32'd0);
    start = 1'b1;
    funct3 = f;
    rs1 = a;
    rs2 = b;
    @(negedge clk);
    start = 1'b0;
    pushExpect(tag, exp, cyc);
  endtask

  task automatic waitIdle();
    int guard = 0;
    while (sb.size() != 0 && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    checkOutput("drain", sb.size(), 32'd0);
    sb.delete();
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int bh;
    int d0;
    logic [2:0] f;
    logic [31:0] a, b;
    rst = 1'b1;
    start = 1'b0;
    funct3 = 3'd0;
    rs1 = '0;
    rs2 = '0;
    repeat (3) @(negedge clk);
    checkOutput("reset_busy", {31'b0, busy}, 32'd0);
    checkOutput("reset_done", {31'b0, done}, 32'd0);
    checkOutput("reset_result", result, 32'd0);
    rst = 1'b0;

    // MUL with cycle-by-cycle busy profile
    applyStimulus("mul", 3'd0, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB);
    bh = busy ? 1 : 0;
    repeat (32) begin
      @(negedge clk);
      bh += busy ? 1 : 0;
    end
    checkOutput("busy_high_cycles", bh, 32'd33);
    @(negedge clk);
    checkOutput("busy_low_at_done", {31'b0, busy}, 32'd0);
    checkOutput("done_at_33", {31'b0, done}, 32'd1);
    @(negedge clk);
    checkOutput("done_one_cycle", {31'b0, done}, 32'd0);
    waitIdle();

    applyStimulus("mulh", 3'd1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000);  waitIdle();
    applyStimulus("mulhu", 3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE); waitIdle();
    applyStimulus("mulhsu", 3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF); waitIdle();
    applyStimulus("div", 3'd4, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD);          waitIdle();
    applyStimulus("rem", 3'd6, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF);          waitIdle();
    applyStimulus("divu", 3'd5, 32'hFFFF_FFF9, 32'd2, 32'h7FFF_FFFC);         waitIdle();
    applyStimulus("divu_by0", 3'd5, 32'd5, 32'd0, 32'hFFFF_FFFF);             waitIdle();
    applyStimulus("rem_by0", 3'd6, 32'd5, 32'd0, 32'd5);                      waitIdle();
    applyStimulus("div_by0", 3'd4, 32'd5, 32'd0, 32'hFFFF_FFFF);              waitIdle();
    applyStimulus("div_ovf", 3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000); waitIdle();
    applyStimulus("rem_ovf", 3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0);      waitIdle();

    // Start pulse and operand changes mid-operation must be ignored
    d0 = done_cnt;
    applyStimulus("midop_divu", 3'd5, 32'd1000, 32'd10, 32'd100);
    repeat (5) @(negedge clk);
    funct3 = 3'd0;
    rs1 = 32'd7;
    rs2 = 32'd1;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    waitIdle();
    repeat (40) @(negedge clk);
    checkOutput("midop_done_count", done_cnt - d0, 32'd1);

    // Reset at iteration ~10 aborts the op immediately
    applyStimulus("aborted", 3'd0, 32'd5, 32'd6, 32'd30);
    repeat (10) @(negedge clk);
    rst = 1'b1;
    #1;
    checkOutput("abort_busy", {31'b0, busy}, 32'd0);
    checkOutput("abort_done", {31'b0, done}, 32'd0);
    checkOutput("abort_result", result, 32'd0);
    sb.delete();
    @(negedge clk);
    rst = 1'b0;
    applyStimulus("mul_after_reset", 3'd0, 32'd3, 32'd4, 32'd12);
    waitIdle();

    // Back-to-back with start held high through the done cycle
    @(negedge clk);
    start = 1'b1;
    funct3 = 3'd5;
    rs1 = 32'd100;
    rs2 = 32'd7;
    @(negedge clk);
    pushExpect("b2b_divu", 32'd14, cyc);
    funct3 = 3'd7;
    bh = 0;
    while (!done && bh < 100) begin
      @(negedge clk);
      bh++;
    end
    checkOutput("b2b_first_done", {31'b0, done}, 32'd1);
    pushExpect("b2b_remu", 32'd2, cyc + 1);
    @(negedge clk);
    start = 1'b0;
    waitIdle();

    // Randomised ops against the reference model
    for (int i = 0; i < 8; i++) begin
      f = 3'($urandom_range(0, 7));
      a = $urandom;
      b = ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom;
      if (i[0]) b = b & 32'h0000_00FF;
      applyStimulus("rand", f, a, b, refModel(f, a, b));
      waitIdle();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/muldiv_unit.md
# muldiv_unit

Iterative RV32M multiply/divide unit downstream of the register file. It consumes the `rs1`/`rs2` read-port values and a `funct3` opcode. It then produces the 32-bit M-extension result after a fixed multi-cycle latency, for write-back through the register file's `rd`/`rdi`/`write_enable` port. It uses a start/busy/done handshake so the core can stall while the operation runs.

## Interface
- `XLEN`, default 32: operand/result width. Only 32 is supported.
- `clk`  in  1  rising-edge clock
- `rst`  in  1  asynchronous, active-high reset
- `start`  in  1  request; sampled only when `busy`=0
- `funct3`  in  3  000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
- `rs1`  in  32  operand A (dividend / multiplicand)
- `rs2`  in  32  operand B (divisor / multiplier)
- `busy`  out  1  high from the accept edge until the `done` edge
- `done`  out  1  one-cycle pulse; `result` is valid from this cycle on
- `result`  out  32  registered result; holds until the next `done`

## Operation
- States: IDLE, CALC, FIX.
- IDLE: on `start`=1, capture `funct3`, operand signs, and operand magnitudes.
  - Signed treatment: MULH, DIV and REM take both operands as signed.
  - MULHSU takes `rs1` signed and `rs2` unsigned.
  - MUL, MULHU, DIVU and REMU take both unsigned. MUL is unsigned because its low word is sign-independent.
  - On accept: clear the 6-bit iteration counter, set `busy`, go to CALC.
- CALC: one iteration per cycle, 32 iterations, then go to FIX.
  - Multiply: radix-2 shift-add into a 64-bit accumulator.
  - Divide: restoring division producing a 32-bit quotient and a 32-bit remainder.
- FIX: apply sign correction and select the output, then register `result`, pulse `done`, clear `busy`, go to IDLE.
  - Multiply: negate the 64-bit product if the result sign is 1. The result sign is `s1^s2` for MULH, `s1` for MULHSU, and 0 otherwise.
  - MUL returns the low word. MULH, MULHSU and MULHU return the high word.
  - Divide: the quotient is negated if `s1^s2`. The remainder takes the sign of the dividend.
- Division by zero overrides the computed result in FIX:
  - quotient = 0xFFFFFFFF for both DIV and DIVU;
  - remainder = `rs1` as captured.
- Signed overflow (DIV/REM with 0x80000000 / 0xFFFFFFFF) overrides the computed result in FIX: quotient = 0x80000000, remainder = 0.
- Special cases do not shorten latency; every op takes the same number of cycles.
- `start` while `busy`=1 is ignored; no queuing.
- Changes on `rs1`/`rs2`/`funct3` after the accept edge have no effect.

## Timing
- Reset (async assert, any state): state=IDLE, `busy`=0, `done`=0, `result`=0, counter=0, accumulators=0.
- Reset mid-operation aborts the operation. No `done` pulse is produced for the aborted op.
- Accept edge E0: `busy`=1 after E0.
- Iterations run on edges E1..E32.
- FIX at E33: `result` and `done`=1 become visible after E33, and `busy`=0 after E33.
- Latency is 33 cycles from the accept edge to `done`.
- `done` is high for exactly one cycle and deasserts after E34.
- Back-to-back operation: `start` held high in the `done` cycle is accepted at E34, because `busy`=0 then. The next `done` follows at E67.
- Throughput is one op per 34 cycles.
- The counter is 6 bits and does not wrap: CALC exits when the counter reaches 31.

## Test plan
- MUL 7 × 0xFFFFFFFD (−3) -> `result`=0xFFFFFFEB. `done` exactly 33 cycles after accept; `busy` high for cycles 1–33.
- MULH 0x80000000 × 0x80000000 -> 0x40000000.
- MULHU 0xFFFFFFFF × 0xFFFFFFFF -> 0xFFFFFFFE.
- MULHSU 0xFFFFFFFF × 0xFFFFFFFF -> 0xFFFFFFFF.
- DIV 0xFFFFFFF9 (−7) / 2 -> 0xFFFFFFFD.
- REM of the same operands -> 0xFFFFFFFF.
- DIVU 0xFFFFFFF9 / 2 -> 0x7FFFFFFC.
- Divide by zero, operands 5 / 0:
  - DIVU -> 0xFFFFFFFF;
  - REM -> 5;
  - DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000;
  - REM of the same operands -> 0.
- Change `rs1`/`rs2` and pulse `start` mid-op -> ignored; the original result is produced with a single `done`.
- Assert `rst` at iteration 10 -> `busy`/`done`/`result` go to 0 immediately. A new MUL 3 × 4 started after reset -> 12 after 33 cycles.
- Back-to-back sequence DIVU 100 / 7 then REMU 100 / 7 with `start` held high -> 14 then 2, `done` pulses 34 cycles apart.
